store_commit_buffer: RTL

- Sits directly downstream of the store queue.
- Accepts retired stores (store_wb pulse plus the entry's addr, ps2_data and sw/sh flag) into a small FIFO.
- Converts each store to a word-aligned address, byte enables and lane-shifted data.
- Drains stores one at a time to the data memory over a req/ready handshake.
- Tells the load path when a pending store overlaps a load's word, so the load is held off.

---
 rtl/store_commit_buffer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/store_commit_buffer.sv
// Store commit buffer: FIFO of retired, lane-formatted stores drained to data memory.
// Optional store-to-load forwarding outputs are enabled with `define STORE_FWD_EN.
module store_commit_buffer #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        store_wb,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        st_sh,
    output logic        full,
    output logic        empty,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    output logic        err_misaligned,
`ifdef STORE_FWD_EN
    input  logic [1:0]  ld_size,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    output logic [3:0]  fwd_be,
`endif
    output logic        overflow
);

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    entry_t             ent_q [DEPTH];
    logic [DEPTH-1:0]   vld_q;
    logic [PTR_W-1:0]   w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [PTR_W:0]     cnt_q, cnt_d;
    logic               ovf_q, ovf_d, err_q, err_d;

    logic        aligned;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_data;
    logic        push, pop;

    // Lane formatting happens on the way in, so the drain side is a plain mux.
    always_comb begin
        aligned  = 1'b0;
        fmt_be   = 4'b0000;
        fmt_data = 32'h0;
        if (!st_sh) begin
            aligned  = (st_addr[1:0] == 2'b00);
            fmt_be   = 4'b1111;
            fmt_data = st_data;
        end else begin
            case (st_addr[1:0])
                2'b00: begin
                    aligned  = 1'b1;
                    fmt_be   = 4'b0011;
                    fmt_data = {16'h0, st_data[15:0]};
                end
                2'b10: begin
                    aligned  = 1'b1;
                    fmt_be   = 4'b1100;
                    fmt_data = {st_data[15:0], 16'h0};
                end
                default: ;
            endcase
        end
    end

    assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign mem_req = !empty;
    assign pop     = mem_req && mem_ready;
    assign push    = store_wb && aligned && (!full || pop);

    always_comb begin
        w_ptr_d = push ? w_ptr_q + PTR_W'(1) : w_ptr_q;
        r_ptr_d = pop  ? r_ptr_q + PTR_W'(1) : r_ptr_q;
        cnt_d   = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: ;
        endcase
        ovf_d = ovf_q || (store_wb && aligned && full && !pop);
        err_d = store_wb && !aligned;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            vld_q   <= '0;
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Pop before push: when full with push+pop, w_ptr == r_ptr and the new entry must stay valid.
            if (pop) vld_q[r_ptr_q] <= 1'b0;
            if (push) begin
                ent_q[w_ptr_q] <= '{waddr: st_addr[31:2], data: fmt_data, be: fmt_be};
                vld_q[w_ptr_q] <= 1'b1;
            end
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr       = mem_req ? {ent_q[r_ptr_q].waddr, 2'b00} : 32'h0;
    assign mem_wdata      = mem_req ? ent_q[r_ptr_q].data : 32'h0;
    assign mem_be         = mem_req ? ent_q[r_ptr_q].be : 4'b0000;
    assign overflow       = ovf_q;
    assign err_misaligned = err_q;

`ifdef STORE_FWD_EN
    logic             match;
    logic [PTR_W-1:0] idx;
    logic [3:0]       need;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        match    = 1'b0;
        fwd_data = 32'h0;
        fwd_be   = 4'b0000;
        idx      = r_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_ptr_q + PTR_W'(k);
            if (vld_q[idx] && ent_q[idx].waddr == ld_addr[31:2]) begin
                match    = ld_valid;
                fwd_data = ent_q[idx].data;
                fwd_be   = ent_q[idx].be;
            end
        end
        case (ld_size)
            2'b00:   need = 4'b0001 << ld_addr[1:0];
            2'b01:   need = 4'b0011 << {ld_addr[1], 1'b0};
            default: need = 4'b1111;
        endcase
        fwd_hit     = match && ((fwd_be & need) == need);
        ld_conflict = match && !fwd_hit;
    end
`else
    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (vld_q[i] && ent_q[i].waddr == ld_addr[31:2]) ld_conflict = ld_valid;
    end
`endif

endmodule
